// File: rtl/priority_arbiter_if.sv
// rtl/priority_arbiter_if.sv - request/grant bundle between requesters and the priority arbiter
interface priority_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     num;
  logic             ack;
  logic             gnt_valid;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] ub;

  modport master (output num, ack, input gnt_valid, gnt, ub);
  modport slave  (input num, ack, output gnt_valid, gnt, ub);
endinterface

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - registered fixed-priority / round-robin arbiter with ack handshake
module priority_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  priority_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic             valid_r, valid_n;
  logic [N-1:0]     gnt_r, gnt_n;
  logic [IDX_W-1:0] ub_r, ub_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] scan_base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win;

  // On an acked grant the scan must already use the pointer being loaded, i.e. ub_r.
  always_comb begin
    win       = '0;
    cand      = '0;
    scan_base = (state == GRANT) ? ub_r : ptr;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.num[i]) win = IDX_W'(i);
      end
    end else begin
      // Walk the scan order backwards so the last hit is the first in priority.
      for (int k = N; k >= 1; k--) begin
        cand = IDX_W'((int'(scan_base) + N - k) % N);
        if (bus.num[cand]) win = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    valid_n = valid_r;
    gnt_n   = gnt_r;
    ub_n    = ub_r;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (|bus.num) begin
          state_n    = GRANT;
          valid_n    = 1'b1;
          ub_n       = win;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
        end else begin
          valid_n = 1'b0;
          gnt_n   = '0;
          ub_n    = '0;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          if (MODE != 0) ptr_n = ub_r;
          if (|bus.num) begin
            valid_n    = 1'b1;
            ub_n       = win;
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            gnt_n   = '0;
            ub_n    = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        gnt_n   = '0;
        ub_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_r <= 1'b0;
      gnt_r   <= '0;
      ub_r    <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      valid_r <= valid_n;
      gnt_r   <= gnt_n;
      ub_r    <= ub_n;
      ptr     <= ptr_n;
    end
  end

  assign bus.gnt_valid = valid_r;
  assign bus.gnt       = gnt_r;
  assign bus.ub        = ub_r;

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 2..32.
REQ-002 Parameter IDX_W, default 3: index width; SHALL equal ceil(log2(N)).
REQ-003 Parameter MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 num  input  N: request vector; bit i set = requester i active.
REQ-007 ack  input  1: consumer accepts the current grant; ignored while gnt_valid=0.
REQ-008 gnt_valid  output  1: a grant is being presented.
REQ-009 gnt  output  N: one-hot grant; SHALL be all-zero when gnt_valid=0.
REQ-010 ub  output  IDX_W: binary index of the granted bit; SHALL be 0 when gnt_valid=0.

Function
REQ-011 The block SHALL have two states, IDLE and GRANT; all outputs SHALL be driven from registers, with no combinational path from inputs to outputs.
REQ-012 Winner selection in MODE=0 SHALL pick the highest set bit of num.
REQ-013 Winner selection in MODE=1 SHALL scan indices ptr-1, ptr-2, ..., 0, N-1, ..., ptr (mod N) and pick the first set bit, where ptr is an internal IDX_W register holding the last acknowledged index.
REQ-014 In IDLE, at a clock edge with num!=0, the block SHALL:
- register the winner into ub and gnt;
- set gnt_valid=1;
- enter GRANT.
Latency is 1 cycle from num first sampled nonzero.
REQ-015 In IDLE, at an edge with num==0, the block SHALL stay in IDLE with all outputs at zero.
REQ-016 In GRANT with ack=0, ub, gnt and gnt_valid SHALL hold stable regardless of num, including when the granted bit drops.
REQ-017 In GRANT with ack=1, at the edge:
- ptr SHALL load ub (MODE=1; ptr is unused in MODE=0);
- if num!=0, the next winner SHALL be computed using the updated ptr, registered, and the block SHALL remain in GRANT (back-to-back, no bubble);
- otherwise the block SHALL return to IDLE with outputs zeroed.
REQ-018 gnt SHALL always equal (1 << ub) when gnt_valid=1; exactly one bit SHALL be set.
REQ-019 Wrap-around: in MODE=1 with ptr=0, the scan SHALL start at N-1; with ptr=N-1, the scan SHALL start at N-2 and reach N-1 last.
REQ-020 In MODE=0, a requester acknowledged while still requesting and still highest SHALL be re-granted immediately (starvation of lower indices is permitted).
REQ-021 If N is not a power of two, indices >= N SHALL never appear on ub.

Reset
REQ-022 At an edge with rst=1, the block SHALL enter IDLE and set gnt_valid=0, gnt=0, ub=0 and ptr=0, regardless of state, num or ack.
REQ-023 rst SHALL take precedence over ack and num at the same edge; a grant in flight SHALL be discarded without updating ptr.
REQ-024 With ptr=0 after reset, the first round-robin decision SHALL equal the fixed-priority decision.

Verification (N=8)
REQ-025 MODE=0: num=8'b01001100 -> one edge later gnt_valid=1, ub=6, gnt=8'b01000000; after ack with num=8'b00001011 -> ub=3; then ack with num=8'b00000001 -> ub=0.
REQ-026 Hold: grant at ub=6 with ack=0, num changed to 8'b10000000 for 3 cycles -> ub stays 6, gnt stays 8'b01000000; ack pulse -> next edge ub=7.
REQ-027 MODE=1: num=8'hFF held, ack=1 every cycle -> ub sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, gnt_valid continuously 1.
REQ-028 MODE=1 wrap: ptr=1 (after acking ub=1), num=8'b00000011 -> ub=0; ack -> ub=1.
REQ-029 ack=1 with num=0 in GRANT -> next edge gnt_valid=0, gnt=0, ub=0; ack=1 while IDLE and num=0 -> no change.
REQ-030 rst=1 asserted while gnt_valid=1 and ack=1 -> next edge all outputs 0, ptr=0; with num=8'hFF after release -> ub=7 in MODE=1.
